// File: rtl/carbon_arch_pkg.sv
// rtl/carbon_arch_pkg.sv - CAI architectural constants shared across the host blocks
package carbon_arch_pkg;

    localparam int CARBON_CAI_SUBMIT_DESC_V1_SIZE_BYTES = 64;

    localparam logic [15:0] CARBON_CAI_STATUS_OK       = 16'h0000;
    localparam logic [15:0] CARBON_CAI_STATUS_BAD_DESC = 16'h0001;
    localparam logic [15:0] CARBON_CAI_STATUS_FAULT    = 16'h0002;

endpackage

// File: rtl/carbon_cai_sched_pkg.sv
// rtl/carbon_cai_sched_pkg.sv - types shared by the CAI submit scheduler
package carbon_cai_sched_pkg;

    localparam int CAI_SCHED_IDX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [63:0]                base;
        logic [CAI_SCHED_IDX_W-1:0] mask;
        logic                       en;
    } ctx_cfg_t;

endpackage

// File: rtl/cai_rr_pick.sv
// rtl/cai_rr_pick.sv - combinational first-set finder starting at a rotating pointer
module cai_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/cai_submit_sched.sv
// rtl/cai_submit_sched.sv - round-robin submit scheduler sharing one CAI device across contexts
module cai_submit_sched
    import carbon_cai_sched_pkg::*;
#(
    parameter int NUM_CTX        = 4,
    parameter int DESC_BYTES     = carbon_arch_pkg::CARBON_CAI_SUBMIT_DESC_V1_SIZE_BYTES,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_we,
    input  logic [$clog2(NUM_CTX)-1:0]         cfg_ctx,
    input  logic [63:0]                        cfg_base,
    input  logic [15:0]                        cfg_mask,
    input  logic                               cfg_en,
    output logic                               cfg_rej,
    input  logic                               db_valid,
    input  logic [$clog2(NUM_CTX)-1:0]         db_ctx,
    input  logic [15:0]                        db_tail,
    output logic                               db_err,
    output logic                               dev_valid,
    input  logic                               dev_ready,
    output logic [63:0]                        dev_desc_addr,
    output logic [15:0]                        dev_context_id,
    input  logic                               dev_done,
    input  logic [15:0]                        dev_status,
    output logic [NUM_CTX-1:0]                 done_pulse,
    output logic [NUM_CTX-1:0]                 err_timeout,
    output logic                               busy,
    output logic [CAI_SCHED_IDX_W*NUM_CTX-1:0] head_out
);

    localparam int CW     = $clog2(NUM_CTX);
    localparam int IW     = CAI_SCHED_IDX_W;
    localparam int OFF_SH = $clog2(DESC_BYTES);
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

    ctx_cfg_t      cfg_q  [NUM_CTX];
    logic [IW-1:0] head_q [NUM_CTX];
    logic [IW-1:0] tail_q [NUM_CTX];

    sched_state_t state;
    logic [CW-1:0] cur_ctx;
    logic [CW-1:0] rr_ptr;
    logic [TW-1:0] timer;
    logic          abort_q;

    logic [NUM_CTX-1:0] pending;
    logic               pick_found;
    logic [CW-1:0]      pick_idx;
    logic               cfg_hit_flight;
    logic [IW-1:0]      db_room;
    logic               db_ok;
    logic [63:0]        pick_offset;
    logic               unused_status;

    // A context being reconfigured this cycle is hidden from the picker so a stale entry is never issued.
    always_comb begin
        pending = '0;
        for (int c = 0; c < NUM_CTX; c++) begin
            pending[c] = cfg_q[c].en && (tail_q[c] != head_q[c]) && !(cfg_we && cfg_ctx == CW'(c));
        end
    end

    cai_rr_pick #(.N(NUM_CTX), .W(CW)) u_pick (
        .req   (pending),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cfg_hit_flight = cfg_we && (state != ST_IDLE) && (cfg_ctx == cur_ctx);
    assign db_room        = db_tail - head_q[db_ctx];
    assign db_ok          = db_valid && cfg_q[db_ctx].en
                            && ({1'b0, db_room} <= ({1'b0, cfg_q[db_ctx].mask} + 17'd1))
                            && !(cfg_we && cfg_ctx == db_ctx);
    assign pick_offset    = {48'b0, head_q[pick_idx] & cfg_q[pick_idx].mask} << OFF_SH;
    assign busy           = (state != ST_IDLE);
    assign unused_status  = ^dev_status;

    for (genvar g = 0; g < NUM_CTX; g++) begin : g_head
        assign head_out[IW*g +: IW] = head_q[g];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                cfg_q[c]  <= '0;
                head_q[c] <= '0;
                tail_q[c] <= '0;
            end
            state          <= ST_IDLE;
            cur_ctx        <= '0;
            rr_ptr         <= '0;
            timer          <= '0;
            abort_q        <= 1'b0;
            dev_valid      <= 1'b0;
            dev_desc_addr  <= '0;
            dev_context_id <= '0;
            done_pulse     <= '0;
            err_timeout    <= '0;
            cfg_rej        <= 1'b0;
            db_err         <= 1'b0;
        end else begin
            cfg_rej    <= cfg_hit_flight;
            db_err     <= db_valid && !db_ok;
            done_pulse <= '0;

            if (db_ok) tail_q[db_ctx] <= db_tail;

            if (cfg_we && !cfg_hit_flight) begin
                cfg_q[cfg_ctx].base  <= cfg_base;
                cfg_q[cfg_ctx].mask  <= cfg_mask;
                cfg_q[cfg_ctx].en    <= cfg_en;
                head_q[cfg_ctx]      <= '0;
                tail_q[cfg_ctx]      <= '0;
                err_timeout[cfg_ctx] <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        cur_ctx        <= pick_idx;
                        dev_desc_addr  <= cfg_q[pick_idx].base + pick_offset;
                        dev_context_id <= IW'(pick_idx);
                        dev_valid      <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (dev_ready) begin
                        dev_valid <= 1'b0;
                        timer     <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dev_done) begin
                        abort_q <= 1'b0;
                        state   <= ST_RETIRE;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout[cur_ctx] <= 1'b1;
                        abort_q              <= 1'b1;
                        state                <= ST_RETIRE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_RETIRE: begin
                    head_q[cur_ctx]     <= head_q[cur_ctx] + IW'(1);
                    done_pulse[cur_ctx] <= !abort_q;
                    rr_ptr              <= (cur_ctx == CW'(NUM_CTX - 1)) ? '0 : cur_ctx + CW'(1);
                    state               <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
